muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage of the pipelined MIPS core.
- Supports MULT, MULTU, DIV and DIVU, and produces HI/LO results.
- While busy it raises a stall request toward the pipeline control unit. A branch/exception flush can cancel it mid-operation.
- Width and radix (bits retired per cycle) are parametrised, so a single block serves 32-bit and narrower test configurations.

Parameters:
- WIDTH, 32, operand/result width. Must be even and >= 4.
- ITER, 1, bits retired per CALC cycle (1 or 2). Must divide WIDTH. N = WIDTH/ITER.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  request a new operation. Sampled only in IDLE.
- op_i  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src1_i  in  WIDTH  multiplicand / dividend.
- src2_i  in  WIDTH  multiplier / divisor.
- cancel_i  in  1  flush; aborts the operation in progress.
- busy_o  out  1  high in CALC and FIX.
- stallreq_o  out  1  stall request to ctrl.
- done_o  out  1  one-cycle pulse; results are valid this cycle.
- hi_o  out  WIDTH  product high half / remainder.
- lo_o  out  WIDTH  product low half / quotient.
- div_zero_o  out  1  the last completed division had divisor 0. Held until the next done_o.

Behaviour:
- Reset: state IDLE; busy_o=0, stallreq_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0; counter=0. rst has priority over all other inputs in every state.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 and cancel_i=0 -> latch op, absolute operand values, sign flags and counter=0.
  - If the op is DIV/DIVU and src2_i==0, go directly to DONE with the div-zero flag set. Otherwise go to CALC.
  - start_i with cancel_i=1 is ignored.
- CALC:
  - Each cycle performs ITER steps: shift-add for multiply, restoring shift-subtract for divide, on unsigned magnitudes.
  - At the edge where counter==N-1, go to FIX; otherwise counter+1.
- FIX:
  - Signed MULT: the 2*WIDTH product is negated if the operand signs differ.
  - Signed DIV: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Overflow case -2^(WIDTH-1) / -1 wraps: quotient = -2^(WIDTH-1), remainder = 0.
  - Next state DONE.
- DONE:
  - done_o=1; hi_o/lo_o/div_zero_o are updated at the edge entering DONE.
  - Divide by zero: hi_o = dividend, lo_o = all ones.
  - Unconditionally return to IDLE next edge; start_i is ignored in DONE.
- Latency: done_o asserts N+1 clock edges after the edge that sampled start_i (33 for WIDTH=32, ITER=1; 17 for ITER=2). Divide-by-zero completes after 1 edge.
- stallreq_o = (IDLE & start_i & ~cancel_i) | CALC | FIX. This is combinational, so the issuing instruction holds in EX from its first cycle. stallreq_o is low in DONE so the pipeline advances and captures the result.
- cancel_i in CALC/FIX/DONE -> IDLE at next edge. No done_o is produced; hi_o/lo_o/div_zero_o keep their previous values. If start_i and cancel_i are both high in the same cycle, cancel wins.
- start_i while busy is ignored; operands are not re-sampled.
- Outputs are registered except stallreq_o.

Optional Feature:
- Macro: MULDIV_HILO_EN.
- Defined:
  - Adds ports hilo_we_i (in, 1), hilo_sel_i (in, 1; 0=LO, 1=HI) and hilo_wdata_i (in, WIDTH) for MTHI/MTLO.
  - hi_o/lo_o become architectural HI/LO registers.
  - An MTHI/MTLO write in IDLE updates the selected register at the next edge.
  - hilo_we_i while busy is ignored.
  - A DONE update takes priority over a simultaneous write.
- Not defined: no extra ports; hi_o/lo_o are plain result registers as described above.

Test Plan:
- MULT src1=0xFFFFFFFD (-3), src2=7, WIDTH=32, ITER=1 -> done_o 33 edges after start; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; stallreq_o high for exactly 33 cycles.
- DIVU 100/7 -> lo_o=14, hi_o=2, div_zero_o=0. DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU 5/0 -> done_o one edge after start; div_zero_o=1, hi_o=5, lo_o=0xFFFFFFFF; busy_o never asserted.
- MULTU 0x80000000*2 completes; then start DIV, with cancel_i pulsed on the 10th CALC cycle -> IDLE next edge, no done_o, hi_o=1/lo_o=0 retained; a new start the following cycle is accepted.
- rst asserted on the 5th CALC cycle -> next edge all outputs 0, state IDLE. Same DIVU 100/7 with ITER=2 -> done_o after 17 edges, identical results.
- (MULDIV_HILO_EN) MTHI 0x1234 in IDLE -> hi_o=0x1234 next edge. hilo_we_i during CALC is ignored. A write coinciding with the DONE-entry edge is overridden by the result.

Source files
------------

// File: rtl/muldiv_iter_if.sv
// Issue/result bundle between the EX stage and the iterative mul/div unit.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             cancel_i;
    logic             busy_o;
    logic             stallreq_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             div_zero_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, cancel_i,
        input  busy_o, stallreq_o, done_o, hi_o, lo_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, cancel_i,
        output busy_o, stallreq_o, done_o, hi_o, lo_o, div_zero_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO, ITER bits per cycle.
// Optional MTHI/MTLO write port enabled by defining MULDIV_HILO_EN.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MULDIV_HILO_EN
    input  logic             hilo_we_i,
    input  logic             hilo_sel_i,
    input  logic [WIDTH-1:0] hilo_wdata_i,
`endif
    muldiv_iter_if.slave     bus
);
    localparam int N  = WIDTH / ITER;
    localparam int CW = $clog2(N);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d, p_step;
    logic [WIDTH-1:0] a_q, a_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic             sgn, s1neg, s2neg, is_div;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH-1:0] fix_hi, fix_lo, quo, rem;
    logic [PW-1:0]    prod;

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    function automatic logic [PW-1:0] step(
        input logic [PW-1:0]    p,
        input logic [WIDTH-1:0] a,
        input logic             dv
    );
        logic [WIDTH:0] s;
        logic [PW-1:0]  r;
        if (dv) begin
            s = {p[PW-1:WIDTH], p[WIDTH-1]} - {1'b0, a};
            if (!s[WIDTH])
                r = {s[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
            else
                r = {p[PW-2:0], 1'b0};
        end else begin
            s = {1'b0, p[PW-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
            r = {s, p[WIDTH-1:1]};
        end
        return r;
    endfunction

    always_comb begin
        p_step = p_q;
        for (int i = 0; i < ITER; i++)
            p_step = step(p_step, a_q, div_q);
    end

    always_comb begin
        sgn    = ~bus.op_i[0];
        is_div = bus.op_i[1];
        s1neg  = sgn & bus.src1_i[WIDTH-1];
        s2neg  = sgn & bus.src2_i[WIDTH-1];
        abs1   = s1neg ? -bus.src1_i : bus.src1_i;
        abs2   = s2neg ? -bus.src2_i : bus.src2_i;
        prod   = neg_q ? -p_q : p_q;
        quo    = p_q[WIDTH-1:0];
        rem    = p_q[PW-1:WIDTH];
        fix_hi = prod[PW-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_q) begin
            fix_hi = rneg_q ? -rem : rem;
            fix_lo = neg_q ? -quo : quo;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
`ifdef MULDIV_HILO_EN
                if (hilo_we_i) begin
                    if (hilo_sel_i) hi_d = hilo_wdata_i;
                    else            lo_d = hilo_wdata_i;
                end
`endif
                if (bus.start_i && !bus.cancel_i) begin
                    cnt_d  = '0;
                    div_d  = is_div;
                    neg_d  = s1neg ^ s2neg;
                    rneg_d = s1neg;
                    a_d    = is_div ? abs2 : abs1;
                    p_d    = {{WIDTH{1'b0}}, is_div ? abs1 : abs2};
                    if (is_div && bus.src2_i == '0) begin
                        state_d = DONE;
                        hi_d    = bus.src1_i;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.cancel_i) begin
                    state_d = IDLE;
                end else begin
                    p_d = p_step;
                    if (cnt_q == CW'(N - 1)) state_d = FIX;
                    else                     cnt_d   = cnt_q + CW'(1);
                end
            end
            FIX: begin
                if (bus.cancel_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    dz_d    = 1'b0;
                end
            end
            DONE: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    // Combinational so the issuing instruction is held from its first EX cycle.
    assign bus.stallreq_o = (state_q == IDLE && bus.start_i && !bus.cancel_i)
                          || state_q == CALC || state_q == FIX;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.div_zero_o = dz_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: ITER=1 and ITER=2 instances share stimulus.
// MTHI/MTLO steps are compiled in when MULDIV_HILO_EN is defined.
module tb_muldiv_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start  = 1'b0;
    logic         cancel = 1'b0;
    logic [1:0]   op     = 2'b00;
    logic [W-1:0] s1     = '0;
    logic [W-1:0] s2     = '0;
    logic         hwe    = 1'b0;
    logic         hsel   = 1'b0;
    logic [W-1:0] hwd    = '0;
    int           sel    = 0;
    int           checks = 0;
    int           errors = 0;

    muldiv_iter_if #(.WIDTH(W)) if1 ();
    muldiv_iter_if #(.WIDTH(W)) if2 ();

    assign if1.start_i = start;  assign if2.start_i = start;
    assign if1.cancel_i = cancel; assign if2.cancel_i = cancel;
    assign if1.op_i = op;        assign if2.op_i = op;
    assign if1.src1_i = s1;      assign if2.src1_i = s1;
    assign if1.src2_i = s2;      assign if2.src2_i = s2;

    muldiv_iter #(.WIDTH(W), .ITER(1)) u1 (
        .clk(clk),
        .rst(rst),
`ifdef MULDIV_HILO_EN
        .hilo_we_i(hwe),
        .hilo_sel_i(hsel),
        .hilo_wdata_i(hwd),
`endif
        .bus(if1.slave)
    );

    muldiv_iter #(.WIDTH(W), .ITER(2)) u2 (
        .clk(clk),
        .rst(rst),
`ifdef MULDIV_HILO_EN
        .hilo_we_i(1'b0),
        .hilo_sel_i(1'b0),
        .hilo_wdata_i({W{1'b0}}),
`endif
        .bus(if2.slave)
    );

    logic         busy, stall, done, dz;
    logic [W-1:0] hi, lo;
    assign busy  = sel != 0 ? if2.busy_o     : if1.busy_o;
    assign stall = sel != 0 ? if2.stallreq_o : if1.stallreq_o;
    assign done  = sel != 0 ? if2.done_o     : if1.done_o;
    assign dz    = sel != 0 ? if2.div_zero_o : if1.div_zero_o;
    assign hi    = sel != 0 ? if2.hi_o       : if1.hi_o;
    assign lo    = sel != 0 ? if2.lo_o       : if1.lo_o;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        op = o; s1 = a; s2 = b; start = 1'b1;
        #1;
        chk("stall_issue", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done_o, plus stall cycles.
    task automatic wait_done(output int extra, output int stalls,
                             output int busies);
        extra = 0; stalls = 0; busies = 0;
        while (!done && extra < 200) begin
            if (stall) stalls++;
            if (busy) busies++;
            @(negedge clk);
            extra++;
        end
        if (extra >= 200) chk("timeout", 64'(done), 64'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input int lat, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input logic edz);
        int ex, st, bz;
        issue(o, a, b);
        wait_done(ex, st, bz);
        chk({tag, "_lat"}, 64'(ex), 64'(lat));
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        chk({tag, "_dz"}, 64'(dz), 64'(edz));
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int ex, st, bz;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flags", {busy, stall, done, dz}, 4'b0000);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);

        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(ex, st, bz);
        chk("mult_lat", 64'(ex), 64'd33);
        chk("mult_stall_cycles", 64'(st), 64'd33);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        chk("mult_dz", 64'(dz), 64'd0);
        @(negedge clk);

        run("divu", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);

        // A second start while busy must not disturb the running division.
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        op = 2'b01; s1 = 32'd9; s2 = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ex, st, bz);
        chk("div_lat", 64'(ex + 1), 64'd33);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        @(negedge clk);

        run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            32'd0, 32'h8000_0000, 1'b0);

        issue(2'b11, 32'd5, 32'd0);
        chk("dz_busy", 64'(busy), 64'd0);
        wait_done(ex, st, bz);
        chk("dz_lat", 64'(ex), 64'd0);
        chk("dz_flag", 64'(dz), 64'd1);
        chk("dz_hi", 64'(hi), 64'd5);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dz_busy_done", 64'(busy), 64'd0);
        @(negedge clk);

        run("multu", 2'b01, 32'h8000_0000, 32'd2, 33, 32'd1, 32'd0, 1'b0);

        issue(2'b10, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        chk("cancel_busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_flags", {busy, done, stall}, 3'b000);
        chk("cancel_hi", 64'(hi), 64'd1);
        chk("cancel_lo", 64'(lo), 64'd0);
        run("after_cancel", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);

        op = 2'b01; s1 = 32'd3; s2 = 32'd3; start = 1'b1; cancel = 1'b1;
        #1;
        chk("start_cancel_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel_busy", 64'(busy), 64'd0);

        issue(2'b00, 32'd12, 32'd12);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flags", {busy, stall, done, dz}, 4'b0000);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);

        sel = 1;
        run("divu_i2", 2'b11, 32'd100, 32'd7, 17, 32'd2, 32'd14, 1'b0);
        run("mult_i2", 2'b00, 32'hFFFF_FFFD, 32'd7, 17,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        sel = 0;

`ifdef MULDIV_HILO_EN
        hwe = 1'b1; hsel = 1'b1; hwd = 32'h1234;
        @(negedge clk);
        hwe = 1'b0;
        chk("mthi", 64'(hi), 64'h1234);
        hwe = 1'b1; hsel = 1'b0; hwd = 32'h5678;
        @(negedge clk);
        hwe = 1'b0;
        chk("mtlo", 64'(lo), 64'h5678);
        issue(2'b01, 32'd6, 32'd7);
        hwe = 1'b1; hsel = 1'b1; hwd = 32'hDEAD;
        @(negedge clk);
        hwe = 1'b0;
        chk("mthi_busy", 64'(hi), 64'h1234);
        wait_done(ex, st, bz);
        chk("hilo_mul_lo", 64'(lo), 64'd42);
        @(negedge clk);
        op = 2'b11; s1 = 32'd9; s2 = 32'd0; start = 1'b1;
        hwe = 1'b1; hsel = 1'b0; hwd = 32'hBEEF;
        @(negedge clk);
        start = 1'b0; hwe = 1'b0;
        chk("hilo_done_prio_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("hilo_done_prio_hi", 64'(hi), 64'd9);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
